// File: rtl/dmem_wait.sv
// Word-addressed data memory with a fixed number of wait states per access.
// The pipeline is held via stall until each access completes, then released for one DONE cycle.
module dmem_wait #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall,
    output logic                  misalign
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WORD_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state;
    logic [3:0]            r_count;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_data_o;

    logic [WORD_W-1:0]     r_word;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_op_wr;
    logic                  r_op_rd;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_access;
    logic                  w_mem_wr;

    assign w_req      = MemRead | MemWrite;
    assign w_in_range = ({2'b00, r_word} < ADDR_WIDTH'(DEPTH));
    assign w_idx      = r_word[IDX_W-1:0];
    assign w_access   = (r_state == BUSY) && (r_count == 4'd0);
    assign w_mem_wr   = w_access && r_op_wr && w_in_range;

    // Stall must rise in the same cycle the request appears, so it is decoded, not registered.
    assign stall    = rst_n & (((r_state == IDLE) & w_req) | (r_state == BUSY));
    assign data_o   = r_data_o;
    assign misalign = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= 4'd0;
            r_err    <= 1'b0;
            r_data_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_err <= 1'b0;
                    if (w_req) begin
                        if (addr[1:0] != 2'b00) begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                            // A rejected read (or read+write conflict) returns zero.
                            if (MemRead) begin
                                r_data_o <= '0;
                            end
                        end else begin
                            r_count <= 4'(WAIT_CYCLES - 1);
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_state <= DONE;
                        if (r_op_wr) begin
                            if (r_op_rd) begin
                                r_data_o <= '0;
                            end
                        end else begin
                            r_data_o <= w_in_range ? r_mem[w_idx] : '0;
                        end
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request is captured once in IDLE; later input changes are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && w_req) begin
            r_word  <= addr[ADDR_WIDTH-1:2];
            r_wdata <= data_i;
            r_op_wr <= MemWrite;
            r_op_rd <= MemRead;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: stall length, read/write data, misalign, range and reset cases.
module tb_dmem_wait;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall;
    logic        misalign;

    int n_err;
    int n_checks;
    logic [31:0] v18;
    logic [31:0] obs;

    dmem_wait #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .addr    (addr),
        .data_i  (data_i),
        .data_o  (data_o),
        .stall   (stall),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One access: counts stall cycles, then checks misalign and data_o in the DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int exp_stall, input logic exp_mis,
                             input logic [31:0] exp_do, input logic check_do, input string tag,
                             output logic [31:0] obs_do);
        int cnt;
        @(posedge clk);
        #1;
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        data_i   = d;
        cnt      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) cnt++;
            else break;
        end
        chk({tag, "_stall"}, 32'(cnt), 32'(exp_stall));
        chk({tag, "_misalign"}, {31'b0, misalign}, {31'b0, exp_mis});
        if (check_do) chk({tag, "_data_o"}, data_o, exp_do);
        obs_do   = data_o;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = 32'hFFFF_FFFF;
        data_i   = 32'hFFFF_FFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err    = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = 32'h0;
        data_i   = 32'h0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        #11;
        rst_n = 1'b1;

        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0, 1'b1, "wr10", obs);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1'b1, "rd10", obs);
        do_access(1'b0, 1'b1, 32'h14, 32'h12345678, 3, 1'b0, 32'hDEADBEEF, 1'b1, "wr14", obs);
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 3, 1'b0, 32'h12345678, 1'b1, "rd14", obs);
        do_access(1'b1, 1'b0, 32'h18, 32'h0, 3, 1'b0, 32'h0, 1'b0, "rd18a", v18);

        // Idle reset pulse: clears data_o but must leave the array intact.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_data_o", data_o, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        do_access(1'b1, 1'b0, 32'h18, 32'h0, 3, 1'b0, v18, 1'b1, "rd18b", obs);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1'b1, "rd10b", obs);
        do_access(1'b0, 1'b1, 32'h20, 32'h11111111, 3, 1'b0, 32'hDEADBEEF, 1'b1, "wr20", obs);
        do_access(1'b0, 1'b1, 32'h00, 32'hCAFEF00D, 3, 1'b0, 32'hDEADBEEF, 1'b1, "wr00", obs);
        do_access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 3, 1'b0, 32'hDEADBEEF, 1'b1, "wr400", obs);
        do_access(1'b1, 1'b0, 32'h400, 32'h0, 3, 1'b0, 32'h0, 1'b1, "rd400", obs);
        do_access(1'b0, 1'b1, 32'h21, 32'h22222222, 1, 1'b1, 32'h0, 1'b1, "wr21", obs);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h11111111, 1'b1, "rd20", obs);
        do_access(1'b1, 1'b0, 32'h00, 32'h0, 3, 1'b0, 32'hCAFEF00D, 1'b1, "rd00", obs);
        do_access(1'b1, 1'b1, 32'h08, 32'h55, 3, 1'b0, 32'h0, 1'b1, "rw08", obs);
        do_access(1'b1, 1'b0, 32'h08, 32'h0, 3, 1'b0, 32'h55, 1'b1, "rd08", obs);
        do_access(1'b1, 1'b0, 32'h23, 32'h0, 1, 1'b1, 32'h0, 1'b1, "rd23", obs);
        do_access(1'b0, 1'b1, 32'h30, 32'h0BADC0DE, 3, 1'b0, 32'h0, 1'b1, "wr30", obs);
        do_access(1'b1, 1'b0, 32'h30, 32'h0, 3, 1'b0, 32'h0BADC0DE, 1'b1, "rd30", obs);

        // Reset asserted while a write to 0x30 is in BUSY must abort it.
        @(posedge clk);
        #1;
        MemWrite = 1'b1;
        addr     = 32'h30;
        data_i   = 32'h0000FFFF;
        @(negedge clk);
        chk("abort_stall_idle", {31'b0, stall}, 32'd1);
        @(negedge clk);
        chk("abort_stall_busy", {31'b0, stall}, 32'd1);
        #1;
        rst_n    = 1'b0;
        MemWrite = 1'b0;
        #1;
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_data_o", data_o, 32'd0);
        chk("abort_misalign", {31'b0, misalign}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        do_access(1'b1, 1'b0, 32'h30, 32'h0, 3, 1'b0, 32'h0BADC0DE, 1'b1, "rd30b", obs);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_wait.md
Name: dmem_wait

Overview:
Data memory placed directly downstream of the MEM stage. It consumes mem_address, write_enable (MemWrite), MemRead and mem_data_i, and returns read data toward MEM/WB. It models a word-addressed RAM with a configurable access latency. A stall output freezes the pipeline until each access completes, replacing the zero-latency combinational data memory.

Parameters:
DATA_WIDTH, 32, width of the data word and of the read and write data buses
ADDR_WIDTH, 32, width of the byte address from the MEM stage
DEPTH, 256, number of words in the array; word index is addr[ADDR_WIDTH-1:2]
WAIT_CYCLES, 2, wait states before an access is performed; legal range 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
MemRead  in  1  read request, level; held stable by the pipeline while stall=1
MemWrite  in  1  write request, level; held stable while stall=1
addr  in  ADDR_WIDTH  byte address (ALU result)
data_i  in  DATA_WIDTH  write data (register read data 2)
data_o  out  DATA_WIDTH  read data, registered
stall  out  1  pipeline hold request
misalign  out  1  one-cycle flag: access rejected because addr[1:0]!=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; counter=0.
  - data_o=0, stall=0, misalign=0.
  - Array contents are not cleared.
  - Reset asserted mid-access aborts the access. No array write occurs after reset assertion.
- Request: req = MemRead | MemWrite.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req=0: stay in IDLE, stall=0.
  - If req=1: stall=1, combinational in the same cycle.
  - On the edge, latch addr, data_i and op. Op is write if MemWrite=1; write wins if both are high, and data_o=0 for that access.
  - If addr[1:0]!=0: go to DONE with err=1.
  - Otherwise: counter=WAIT_CYCLES-1, go to BUSY.
- BUSY:
  - stall=1.
  - If counter!=0: counter-1.
  - If counter==0, perform the access on the edge and go to DONE:
    - Write: array[idx] <= latched data.
    - Read: data_o <= array[idx].
- DONE:
  - stall=0, so the pipeline advances this cycle.
  - misalign=err. On a misaligned access, data_o=0 and the array is untouched.
  - Next state is always IDLE. The request still visible in DONE is already consumed and is never restarted.
  - Clear err.
- Stall length per access: WAIT_CYCLES+1 cycles, then one DONE cycle with stall=0.
  - A misaligned access stalls exactly 1 cycle.
- data_o:
  - Holds its last value outside read completion.
  - Updates only on a read completion, a misaligned read (to 0) or a write-and-read conflict (to 0).
- Out of range (idx >= DEPTH):
  - Read returns 0.
  - Write is dropped.
  - No error flag is raised.
- Back-to-back requests: a new request sampled in the IDLE cycle right after DONE starts normally. There is no bubble requirement beyond the DONE→IDLE step.
- Input changes while BUSY are ignored, because the latched copy is used.

Test Plan:
- WAIT_CYCLES=2: MemWrite, addr=0x10, data_i=0xDEADBEEF → stall=1 for 3 cycles, then 0 in DONE. A later read of 0x10 gives data_o=0xDEADBEEF when stall drops.
- Read of never-written in-range word after write to 0x14=0x12345678, then read 0x18 → data_o=0x12345678 for 0x14, and 0x18 returns the array initial value, unchanged by reset.
- Misaligned write addr=0x21 → stall=1 for exactly 1 cycle, misalign=1 in DONE. A subsequent read of 0x20 shows its previous contents; data_o=0.
- Out-of-range: DEPTH=256, write 0x400 ← 0xA5A5A5A5, then read 0x400 → data_o=0, misalign=0, and word 0 is unchanged.
- Simultaneous MemRead=MemWrite=1 at 0x08 ← 0x55 → word 0x08=0x55, data_o=0. Back-to-back read immediately afterwards returns 0x55.
- Reset mid-access: assert rst_n=0 during BUSY of a write 0x30 ← 0xFFFF → stall=0 and data_o=0 immediately, and after release a read of 0x30 shows the old value.
